aud_dsp_player_feed: RTL

- Playback-side stage that reads recorded 16-bit samples back out of SRAM, starting at address 0, up to the recorded sample count.
- Applies speed control: fast (skip samples), slow constant (repeat samples) or slow linear (interpolate).
- Presents one output sample per DAC frame to the downstream I2S DAC serializer.
- Runs on the audio bit clock, alongside the recorder.

---
 rtl/aud_dsp_player_feed.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/aud_dsp_player_feed.sv
// Playback feed: reads samples from SRAM and applies fast, slow-repeat or slow-interpolate speed control.
// The DAC sample is updated once per daclrck rising edge, a few bclk cycles after the edge.
module aud_dsp_player_feed #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_fast,
  input  logic              i_slow_0,
  input  logic              i_slow_1,
  input  logic [2:0]        i_speed,
  input  logic              i_daclrck,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_dac_data,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_FETCH, S_LATCH, S_CALC, S_END} state_t;
  typedef enum logic [1:0] {M_NORM, M_FAST, M_SLOW0, M_SLOW1} mode_t;

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d, mode_in;
  logic [3:0]        n_q, n_d, n_in, k_q, k_d, k_inc;
  logic [DATA_W-1:0] prev_q, prev_d, cur_q, cur_d, dac_q, dac_d;
  logic [ADDR_W-1:0] addr_q, addr_d, end_q, end_d;
  logic              done_q, done_d, lrck_q, frame_edge;

  logic signed [DATA_W:0]   diff;
  logic signed [DATA_W+3:0] diff_ext, k_ext, n_ext, prod, quot;
  logic [DATA_W-1:0]        interp;
  logic [ADDR_W:0]          step, addr_nxt;
  logic                     advance;

  assign frame_edge = i_daclrck & ~lrck_q;

  always_comb begin
    mode_in = M_NORM;
    if (i_fast)        mode_in = M_FAST;
    else if (i_slow_1) mode_in = M_SLOW1;
    else if (i_slow_0) mode_in = M_SLOW0;
    n_in = (mode_in == M_NORM) ? 4'd1 : ({1'b0, i_speed} + 4'd1);
  end

  // Interpolation: prev + (cur - prev) * k / N, division truncates toward zero.
  always_comb begin
    k_inc    = k_q + 4'd1;
    diff     = $signed({cur_q[DATA_W-1], cur_q}) - $signed({prev_q[DATA_W-1], prev_q});
    diff_ext = {{3{diff[DATA_W]}}, diff};
    k_ext    = {{DATA_W{1'b0}}, k_inc};
    n_ext    = {{DATA_W{1'b0}}, n_q};
    prod     = diff_ext * k_ext;
    quot     = prod / n_ext;
    interp   = prev_q + quot[DATA_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    n_d     = n_q;
    k_d     = k_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    dac_d   = dac_q;
    addr_d  = addr_q;
    end_d   = end_q;
    done_d  = 1'b0;
    advance = 1'b0;
    step     = (mode_q == M_NORM || mode_q == M_FAST) ? {{(ADDR_W-3){1'b0}}, n_q} : {{ADDR_W{1'b0}}, 1'b1};
    addr_nxt = {1'b0, addr_q};

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_end_addr == '0) begin
            done_d = 1'b1;
          end else begin
            end_d   = i_end_addr;
            addr_d  = '0;
            k_d     = '0;
            prev_d  = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (frame_edge) begin
          if (i_pause) begin
            dac_d = '0;
          end else begin
            mode_d = mode_in;
            n_d    = n_in;
            if (mode_in != mode_q) k_d = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        cur_d   = i_sram_data;
        state_d = S_CALC;
      end
      S_CALC: begin
        case (mode_q)
          M_SLOW0, M_SLOW1: begin
            dac_d = (mode_q == M_SLOW1) ? interp : cur_q;
            if (k_inc >= n_q) begin
              k_d     = '0;
              prev_d  = cur_q;
              advance = 1'b1;
            end else begin
              k_d = k_inc;
            end
          end
          default: begin
            dac_d   = cur_q;
            prev_d  = cur_q;
            k_d     = '0;
            advance = 1'b1;
          end
        endcase
        if (advance) addr_nxt = {1'b0, addr_q} + step;
        // Past the last sample the address is held; the final frame keeps its sample.
        if (addr_nxt >= {1'b0, end_q}) begin
          state_d = S_END;
        end else begin
          addr_d  = addr_nxt[ADDR_W-1:0];
          state_d = S_WAIT;
        end
      end
      S_END: begin
        if (frame_edge) begin
          dac_d   = '0;
          done_d  = 1'b1;
          addr_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (i_stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      dac_d   = '0;
      addr_d  = '0;
      k_d     = '0;
      prev_d  = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= M_NORM;
      n_q     <= 4'd1;
      k_q     <= '0;
      prev_q  <= '0;
      cur_q   <= '0;
      dac_q   <= '0;
      addr_q  <= '0;
      end_q   <= '0;
      done_q  <= 1'b0;
      lrck_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      n_q     <= n_d;
      k_q     <= k_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      dac_q   <= dac_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      done_q  <= done_d;
      lrck_q  <= i_daclrck;
    end
  end

  assign o_sram_addr = addr_q;
  assign o_dac_data  = dac_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;

endmodule
